// File: rtl/port_settle_monitor_if.sv
// port_settle_monitor_if: sample stream in, settling verdict out
interface port_settle_monitor_if #(parameter int DW = 12, parameter int CW = 11);
   logic          start;
   logic          smp_valid;
   logic [DW-1:0] smp_data;
   logic          smp_ready;
   logic          busy;
   logic          done;
   logic          settled;
   logic          timeout;
   logic [DW-1:0] settle_val;
   logic [CW-1:0] settle_cnt;
   modport master (output start, smp_valid, smp_data,
                   input smp_ready, busy, done, settled, timeout, settle_val, settle_cnt);
   modport slave  (input start, smp_valid, smp_data,
                   output smp_ready, busy, done, settled, timeout, settle_val, settle_cnt);
endinterface

// File: rtl/port_settle_monitor.sv
// port_settle_monitor: declares port-2 settled after NSTABLE samples within TOL of the run's
// first sample, or timeout after TMO accepted samples
module port_settle_monitor #(
   parameter int DW      = 12,
   parameter int TOL     = 4,
   parameter int NSTABLE = 8,
   parameter int TMO     = 1024,
   parameter int CW      = 11
) (
   input logic                  clk,
   input logic                  rst,
   port_settle_monitor_if.slave bus
);
   localparam int SW = $clog2(NSTABLE + 1);
   typedef enum logic [1:0] {IDLE, TRACK, SETTLED, TIMEOUT} state_e;
   state_e        state_q, state_d;
   logic [DW-1:0] ref_q, ref_d, val_q, val_d;
   logic [SW-1:0] stable_q, stable_d;
   logic [CW-1:0] cnt_q, cnt_d, scnt_q, scnt_d;
   logic          done_q, done_d, settled_q, settled_d, timeout_q, timeout_d;
   logic [DW:0]   diff;
   logic          xfer;
   assign xfer = (state_q == TRACK) && bus.smp_valid;
   // one extra bit so 0 vs 2^DW-1 yields the true distance
   assign diff = (bus.smp_data > ref_q) ? {1'b0, bus.smp_data} - {1'b0, ref_q}
                                        : {1'b0, ref_q} - {1'b0, bus.smp_data};
   always_comb begin
      state_d   = state_q;
      ref_d     = ref_q;
      val_d     = val_q;
      stable_d  = stable_q;
      cnt_d     = cnt_q;
      scnt_d    = scnt_q;
      settled_d = settled_q;
      timeout_d = timeout_q;
      done_d    = 1'b0;
      if (bus.start) begin
         state_d   = TRACK;
         cnt_d     = '0;
         stable_d  = '0;
         settled_d = 1'b0;
         timeout_d = 1'b0;
         val_d     = '0;
         scnt_d    = '0;
      end else if (xfer) begin
         cnt_d = cnt_q + CW'(1);
         if (stable_q == '0 || diff > (DW+1)'(TOL)) begin
            ref_d    = bus.smp_data;
            stable_d = SW'(1);
         end else
            stable_d = stable_q + SW'(1);
         if (stable_d == SW'(NSTABLE)) begin
            state_d   = SETTLED;
            settled_d = 1'b1;
            val_d     = ref_d;
            scnt_d    = cnt_d;
            done_d    = 1'b1;
         end else if (cnt_d == CW'(TMO)) begin
            state_d   = TIMEOUT;
            timeout_d = 1'b1;
            done_d    = 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         ref_q     <= '0;
         val_q     <= '0;
         stable_q  <= '0;
         cnt_q     <= '0;
         scnt_q    <= '0;
         done_q    <= 1'b0;
         settled_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ref_q     <= ref_d;
         val_q     <= val_d;
         stable_q  <= stable_d;
         cnt_q     <= cnt_d;
         scnt_q    <= scnt_d;
         done_q    <= done_d;
         settled_q <= settled_d;
         timeout_q <= timeout_d;
      end
   end
   assign bus.smp_ready  = (state_q == TRACK);
   assign bus.busy       = (state_q == TRACK);
   assign bus.done       = done_q;
   assign bus.settled    = settled_q;
   assign bus.timeout    = timeout_q;
   assign bus.settle_val = val_q;
   assign bus.settle_cnt = scnt_q;
endmodule

// File: tb/tb_port_settle_monitor.sv
// tb_port_settle_monitor: four monitor instances (default, TMO=16, TMO=8, NSTABLE=1) share one
// stimulus stream and are checked every cycle against a sample-history reference model
module tb_port_settle_monitor;
   localparam int TOL = 4;
   int nst_of[4] = '{8, 8, 8, 1};
   int tmo_of[4] = '{1024, 16, 8, 1024};
   logic clk = 0, rst = 1, st = 0, v = 0;
   logic [11:0] d = '0;
   int checks = 0, failures = 0;
   always #5 clk = ~clk;

   port_settle_monitor_if ifa(), ifb(), ifc(), ifd();
   assign {ifa.start, ifa.smp_valid, ifa.smp_data} = {st, v, d};
   assign {ifb.start, ifb.smp_valid, ifb.smp_data} = {st, v, d};
   assign {ifc.start, ifc.smp_valid, ifc.smp_data} = {st, v, d};
   assign {ifd.start, ifd.smp_valid, ifd.smp_data} = {st, v, d};
   port_settle_monitor                  u0 (.clk(clk), .rst(rst), .bus(ifa));
   port_settle_monitor #(.TMO(16))      u1 (.clk(clk), .rst(rst), .bus(ifb));
   port_settle_monitor #(.TMO(8))       u2 (.clk(clk), .rst(rst), .bus(ifc));
   port_settle_monitor #(.NSTABLE(1))   u3 (.clk(clk), .rst(rst), .bus(ifd));

   logic [27:0] act[4];
   assign act[0] = {ifa.smp_ready, ifa.busy, ifa.done, ifa.settled, ifa.timeout, ifa.settle_val, ifa.settle_cnt};
   assign act[1] = {ifb.smp_ready, ifb.busy, ifb.done, ifb.settled, ifb.timeout, ifb.settle_val, ifb.settle_cnt};
   assign act[2] = {ifc.smp_ready, ifc.busy, ifc.done, ifc.settled, ifc.timeout, ifc.settle_val, ifc.settle_cnt};
   assign act[3] = {ifd.smp_ready, ifd.busy, ifd.done, ifd.settled, ifd.timeout, ifd.settle_val, ifd.settle_cnt};

   // model: phase 0 idle, 1 tracking, 2 settled, 3 timed out; history of accepted samples
   int          ph[4], mcnt[4];
   bit          md[4], mset[4], mto[4];
   logic [11:0] mval[4];
   logic [11:0] hq[4][$];

   function automatic int absd(logic [11:0] a, logic [11:0] b);
      return (a > b) ? int'(a) - int'(b) : int'(b) - int'(a);
   endfunction

   // outcome after the inputs now on the pins are clocked in
   task automatic model_step();
      for (int k = 0; k < 4; k++) begin
         md[k] = 0;
         if (rst || st) begin
            ph[k] = rst ? 0 : 1;
            mset[k] = 0; mto[k] = 0; mval[k] = '0; mcnt[k] = 0;
            hq[k].delete();
         end else if (ph[k] == 1 && v) begin
            int n, r;
            hq[k].push_back(d);
            n = hq[k].size();
            r = 0;
            for (int i = 1; i < n; i++) if (absd(hq[k][i], hq[k][r]) > TOL) r = i;
            if (n - r == nst_of[k]) begin
               ph[k] = 2; mset[k] = 1; mval[k] = hq[k][r]; mcnt[k] = n; md[k] = 1;
            end else if (n == tmo_of[k]) begin
               ph[k] = 3; mto[k] = 1; md[k] = 1;
            end
         end
      end
   endtask

   function automatic logic [27:0] expv(int k);
      logic [10:0] c;
      c = mcnt[k][10:0];
      return {ph[k] == 1, ph[k] == 1, md[k], mset[k], mto[k], mval[k], c};
   endfunction

   task automatic compare();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (act[k] !== expv(k)) begin
            failures++;
            $display("FAIL inst%0d outputs got=%h exp=%h t=%0t", k, act[k], expv(k), $time);
         end
      end
   endtask

   task automatic cyc(input bit r_, input bit s_, input bit v_, input logic [11:0] d_);
      @(negedge clk);
      compare();
      rst = r_; st = s_; v = v_; d = d_;
      model_step();
   endtask

   task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] ex);
      checks++;
      if (got !== ex) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, ex);
      end
   endtask

   initial begin
      int acc, guard, base, amp, x, r;
      logic [11:0] s2[12] = '{12'h100, 12'h180, 12'h1C0, 12'h1E0, 12'h1FE, 12'h202,
                              12'h1FE, 12'h202, 12'h1FE, 12'h202, 12'h1FE, 12'h202};
      model_step();
      repeat (3) cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
      lit("reset_busy", ifa.busy, 0);
      lit("reset_cnt", ifa.settle_cnt, 0);
      // eight identical samples
      cyc(0, 1, 0, 0);
      repeat (8) cyc(0, 0, 1, 12'h200);
      cyc(0, 0, 0, 0);
      lit("s1_done", ifa.done, 1);
      lit("s1_val", ifa.settle_val, 12'h200);
      lit("s1_cnt", ifa.settle_cnt, 8);
      lit("s6_tmo8_settled", ifc.settled, 1);
      lit("s6_tmo8_timeout", ifc.timeout, 0);
      lit("nst1_cnt", ifd.settle_cnt, 1);
      cyc(0, 0, 1, 12'h200);
      lit("s1_done_once", ifa.done, 0);
      lit("s1_ready_settled", ifa.smp_ready, 0);
      // converging ramp, run restarts at 0x1FE
      cyc(0, 1, 0, 0);
      foreach (s2[i]) cyc(0, 0, 1, s2[i]);
      cyc(0, 0, 0, 0);
      lit("s2_val", ifa.settle_val, 12'h1FE);
      lit("s2_cnt", ifa.settle_cnt, 12);
      lit("s2_tmo8", ifc.timeout, 1);
      // full-scale alternation never settles
      cyc(0, 1, 0, 0);
      for (int i = 0; i < 16; i++) cyc(0, 0, 1, (i % 2) ? 12'hFFF : 12'h000);
      cyc(0, 0, 0, 0);
      lit("s3_timeout", ifb.timeout, 1);
      lit("s3_done", ifb.done, 1);
      lit("s3_settled", ifb.settled, 0);
      lit("s3_cnt", ifb.settle_cnt, 0);
      // reset mid-run
      cyc(0, 1, 0, 0);
      repeat (3) cyc(0, 0, 1, 12'h300);
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
      lit("s4_busy", ifa.busy, 0);
      lit("s4_done", ifa.done, 0);
      cyc(0, 1, 0, 0);
      repeat (8) cyc(0, 0, 1, 12'h300);
      cyc(0, 0, 0, 0);
      lit("s4_cnt", ifa.settle_cnt, 8);
      // start beats a coincident sample; sparse valids
      cyc(0, 1, 1, 12'h7FF);
      acc = 0; guard = 0;
      while (acc < 8 && guard < 200) begin
         x = $urandom_range(0, 1);
         cyc(0, 0, x[0], 12'h7FF);
         acc += x;
         guard++;
      end
      if (acc < 8) begin
         failures++;
         $display("FAIL s5_budget accepted=%0d required=8", acc);
      end
      cyc(0, 0, 0, 0);
      lit("s5_cnt", ifa.settle_cnt, 8);
      lit("s5_ready", ifa.smp_ready, 0);
      // randomized traffic
      base = 12'h400; amp = 3;
      for (int i = 0; i < 4000; i++) begin
         r = $urandom_range(0, 399);
         if ($urandom_range(0, 39) == 0) begin
            x = $urandom_range(0, 3);
            base = (x == 0) ? 0 : (x == 1) ? 4095 : $urandom_range(0, 4095);
            x = $urandom_range(0, 2);
            amp = (x == 0) ? 2 : (x == 1) ? 6 : 60;
         end
         x = base + $urandom_range(0, 2 * amp) - amp;
         x = (x < 0) ? 0 : (x > 4095) ? 4095 : x;
         cyc(r == 0, r >= 1 && r < 12, $urandom_range(0, 3) != 0, x[11:0]);
      end
      cyc(0, 0, 0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
